// File: rtl/config_uart_word_rx.sv
// config_uart_word_rx
//   UART receiver front end for the fabric configuration path. It packs four
//   accepted bytes, MSB first, into a 32-bit word and presents it as a
//   WriteData/WriteStrobe pair. ComActive is the session-activity signal that
//   the downstream configuration FSM uses as its resync input.
//
//   Build option: define UART_PARITY_EN for 8E1 framing with a live
//   ParityError. Without the macro the frame is 8N1 and ParityError is tied 0.
//
// Ports
//   CLK          clock
//   resetn       asynchronous active-low reset
//   Rx           UART line, asynchronous to CLK, idle high
//   WriteData    last completed word, held until the next word completes
//   WriteStrobe  one-cycle pulse when WriteData updates
//   ComActive    high while a UART session is active
//   FrameError   one-cycle pulse when a stop bit samples 0
//   ParityError  one-cycle pulse on even-parity mismatch (0 without parity)
module config_uart_word_rx #(
    parameter int ClksPerBit      = 434,
    parameter int ActivityTimeout = 100000
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        Rx,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic        FrameError,
    output logic        ParityError
);

    localparam int CntW  = $clog2(ClksPerBit + 1);
    localparam int IdleW = $clog2(ActivityTimeout + 1);

    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [CntW-1:0]  HalfBit  = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0]  FullBit  = CntW'(ClksPerBit);
    localparam logic [IdleW-1:0] IdleOne  = IdleW'(1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(ActivityTimeout - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    // Input synchronizer; both flops reset to the idle line level.
    logic sync1_q;
    logic line_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sync1_q <= Rx;
            line_q  <= sync1_q;
        end
    end

    rx_state_t       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      data_q;
    logic            bad_q;
    logic            frame_err_q;
`ifdef UART_PARITY_EN
    logic            parity_err_q;
`endif

    // cnt_q holds the number of cycles since t0 (START) or since the previous
    // sample, so the first sample lands at half a bit and the rest one full
    // bit apart.
    logic sample_tick;
    assign sample_tick = (state_q == S_START) ? (cnt_q == HalfBit) : (cnt_q == FullBit);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            bad_q        <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (state_q != S_IDLE && state_q != S_WAIT_HIGH)
                cnt_q <= sample_tick ? CntOne : cnt_q + CntOne;

            case (state_q)
                S_IDLE: begin
                    if (!line_q) begin
                        state_q <= S_START;
                        cnt_q   <= CntOne;
                        bad_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        // A line already back high at mid-bit was a glitch.
                        if (line_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        data_q    <= {line_q, data_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (sample_tick) begin
                        if (line_q != ^data_q) begin
                            parity_err_q <= 1'b1;
                            bad_q        <= 1'b1;
                        end
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (sample_tick) begin
                        if (line_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (line_q)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte accepted on a good stop sample; data_q already holds the full byte.
    logic byte_accept;
    assign byte_accept = (state_q == S_STOP) && sample_tick && line_q && !bad_q;

    logic [1:0]       byte_cnt_q;
    logic [23:0]      shift_q;
    logic [31:0]      write_data_q;
    logic             write_strobe_q;
    logic             com_active_q;
    logic [IdleW-1:0] idle_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            byte_cnt_q     <= '0;
            shift_q        <= '0;
            write_data_q   <= '0;
            write_strobe_q <= 1'b0;
            com_active_q   <= 1'b0;
            idle_q         <= '0;
        end else begin
            write_strobe_q <= 1'b0;
            // An accepted byte takes priority over a coincident timeout.
            if (byte_accept) begin
                com_active_q <= 1'b1;
                idle_q       <= '0;
                if (byte_cnt_q == 2'd3) begin
                    write_data_q   <= {shift_q, data_q};
                    write_strobe_q <= 1'b1;
                    byte_cnt_q     <= '0;
                end else begin
                    shift_q    <= {shift_q[15:0], data_q};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                end
            end else if (com_active_q) begin
                idle_q <= idle_q + IdleOne;
                // Drop on the edge where the counter reaches the timeout; it
                // then freezes because com_active_q is low.
                if (idle_q == IdleLast) begin
                    com_active_q <= 1'b0;
                    byte_cnt_q   <= '0;
                end
            end
        end
    end

    assign WriteData   = write_data_q;
    assign WriteStrobe = write_strobe_q;
    assign ComActive   = com_active_q;
    assign FrameError  = frame_err_q;
`ifdef UART_PARITY_EN
    assign ParityError = parity_err_q;
`else
    assign ParityError = 1'b0;
`endif

endmodule

// File: tb/tb_config_uart_word_rx.sv
module tb_config_uart_word_rx;

    localparam int CPB = 8;
    localparam int TO  = 200;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Rx driven low right after edge 0 -> line low after edge 2 -> t0 cycle
    // ends at edge 3; sample n acts at edge 3 + CPB/2 + n*CPB.
    localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic        FrameError;
    logic        ParityError;

    config_uart_word_rx #(.ClksPerBit(CPB), .ActivityTimeout(TO)) dut (
        .CLK        (clk),
        .resetn     (resetn),
        .Rx         (rx),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
        .ComActive  (ComActive),
        .FrameError (FrameError),
        .ParityError(ParityError)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int strobe_cnt, ferr_cnt, perr_cnt, act_cycles;
    int act_rise_cyc, act_fall_cyc, ferr_cyc, perr_cyc;
    logic act_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc_q[$];
    logic [31:0] w, e;
    int          c;

    // Advance one clock and record DUT events, sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (WriteStrobe === 1'b1) begin
            strobe_cnt++;
            obs_q.push_back(WriteData);
            obs_cyc_q.push_back(cyc);
        end
        if (FrameError === 1'b1) begin ferr_cnt++; ferr_cyc = cyc; end
        if (ParityError === 1'b1) begin perr_cnt++; perr_cyc = cyc; end
        if (ComActive === 1'b1) act_cycles++;
        if (ComActive === 1'b1 && !act_prev) act_rise_cyc = cyc;
        if (ComActive !== 1'b1 && act_prev) act_fall_cyc = cyc;
        act_prev = (ComActive === 1'b1);
    endtask

    task automatic clear_events();
        strobe_cnt = 0; ferr_cnt = 0; perr_cnt = 0; act_cycles = 0;
        act_rise_cyc = -1; act_fall_cyc = -1; ferr_cyc = -1; perr_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_PARITY_EN
        rx = par;
        repeat (CPB) tick();
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, output int start_cyc);
        send_frame(d, ^d, 1'b1, start_cyc);
    endtask

    task automatic send_word(input logic [31:0] wd, output int last_start);
        int s;
        exp_q.push_back(wd);
        for (int i = 3; i >= 0; i--) send_byte(wd[i*8 +: 8], s);
        last_start = s;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rx = 1'b1;
        repeat (5) tick();
        checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
        checks++; if (WriteStrobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", WriteStrobe); end
        checks++; if (ComActive !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", ComActive); end
        checks++; if (FrameError !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", FrameError); end
        checks++; if (ParityError !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", ParityError); end
        resetn = 1'b1;
        clear_events();
        repeat (500) tick();
        checks++; if (strobe_cnt != 0) begin failures++; $display("FAIL idle_strobes got=%0d exp=0", strobe_cnt); end
        checks++; if (act_cycles != 0) begin failures++; $display("FAIL idle_active got=%0d exp=0", act_cycles); end
        checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL idle_ferr got=%0d exp=0", ferr_cnt); end
        checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL idle_wdata got=%h exp=0", WriteData); end
        $display("test_reset done");
    endtask

    task automatic test_word_packing();
        int s0, s;
        clear_events();
        exp_q.push_back(32'hFAB0FAB1);
        send_byte(8'hFA, s0);
        checks++; if (act_rise_cyc != s0 + LAT) begin failures++; $display("FAIL active_rise cyc=%0d exp=%0d", act_rise_cyc, s0 + LAT); end
        send_byte(8'hB0, s);
        send_byte(8'hFA, s);
        send_byte(8'hB1, s);
        repeat (4) tick();
        checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL pack_strobes got=%0d exp=1", strobe_cnt); end
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front(); c = obs_cyc_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL pack_unexpected got=%h exp=none", w); end
            else begin
                e = exp_q.pop_front();
                if (w !== e) begin failures++; $display("FAIL pack_word got=%h exp=%h", w, e); end
            end
            checks++; if (c != s + LAT) begin failures++; $display("FAIL pack_strobe_cyc got=%0d exp=%0d", c, s + LAT); end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pack_missing pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("test_word_packing word=%h", WriteData);
    endtask

    task automatic test_timeout();
        int s1, s;
        clear_events();
        send_byte(8'h12, s);
        send_byte(8'h34, s1);
        repeat (250) tick();
        checks++; if (act_fall_cyc != s1 + LAT + TO) begin failures++; $display("FAIL active_fall cyc=%0d exp=%0d", act_fall_cyc, s1 + LAT + TO); end
        checks++; if (ComActive !== 1'b0) begin failures++; $display("FAIL active_after_idle got=%b exp=0", ComActive); end
        exp_q.push_back(32'h01020304);
        send_byte(8'h01, s1);
        checks++; if (act_rise_cyc != s1 + LAT) begin failures++; $display("FAIL active_rerise cyc=%0d exp=%0d", act_rise_cyc, s1 + LAT); end
        send_byte(8'h02, s);
        send_byte(8'h03, s);
        send_byte(8'h04, s);
        repeat (4) tick();
        checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL timeout_strobes got=%0d exp=1", strobe_cnt); end
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front(); c = obs_cyc_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL timeout_unexpected got=%h exp=none", w); end
            else begin
                e = exp_q.pop_front();
                if (w !== e) begin failures++; $display("FAIL timeout_word got=%h exp=%h", w, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_missing pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("test_timeout word=%h", WriteData);
    endtask

    task automatic test_frame_glitch();
        int s;
        clear_events();
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (30) tick();
        checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt); end
        send_frame(8'h55, ^8'h55, 1'b0, s);
        repeat (2 * CPB) tick();
        checks++; if (ferr_cnt != 1) begin failures++; $display("FAIL frame_err_count got=%0d exp=1", ferr_cnt); end
        checks++; if (ferr_cyc != s + LAT) begin failures++; $display("FAIL frame_err_cyc got=%0d exp=%0d", ferr_cyc, s + LAT); end
        send_word(32'hAABBCCDD, s);
        repeat (4) tick();
        checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL frame_strobes got=%0d exp=1", strobe_cnt); end
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front(); c = obs_cyc_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL frame_unexpected got=%h exp=none", w); end
            else begin
                e = exp_q.pop_front();
                if (w !== e) begin failures++; $display("FAIL frame_word got=%h exp=%h", w, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL frame_missing pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("test_frame_glitch word=%h", WriteData);
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int s;
        clear_events();
        exp_q.push_back(32'h03040506);
        send_frame(8'h03, 1'b0, 1'b1, s);
        send_frame(8'h03, 1'b1, 1'b1, s);
        repeat (4) tick();
        checks++; if (perr_cnt != 1) begin failures++; $display("FAIL parity_count got=%0d exp=1", perr_cnt); end
        checks++; if (perr_cyc != s + 3 + CPB / 2 + 9 * CPB) begin failures++; $display("FAIL parity_cyc got=%0d exp=%0d", perr_cyc, s + 3 + CPB / 2 + 9 * CPB); end
        send_byte(8'h04, s);
        send_byte(8'h05, s);
        send_byte(8'h06, s);
        repeat (4) tick();
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front(); c = obs_cyc_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL parity_unexpected got=%h exp=none", w); end
            else begin
                e = exp_q.pop_front();
                if (w !== e) begin failures++; $display("FAIL parity_word got=%h exp=%h", w, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL parity_missing pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("test_parity word=%h", WriteData);
    endtask
`endif

    task automatic test_mid_reset();
        int s;
        logic [7:0] d;
        clear_events();
        send_byte(8'hA1, s);
        send_byte(8'hA2, s);
        d = 8'hA3;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = d[4];
        repeat (CPB / 2) tick();
        resetn = 1'b0;
        rx = 1'b1;
        repeat (3) tick();
        checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL midreset_wdata got=%h exp=0", WriteData); end
        checks++; if (ComActive !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b exp=0", ComActive); end
        resetn = 1'b1;
        repeat (20) tick();
        clear_events();
        send_word(32'h11223344, s);
        repeat (4) tick();
        checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL midreset_strobes got=%0d exp=1", strobe_cnt); end
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front(); c = obs_cyc_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL midreset_unexpected got=%h exp=none", w); end
            else begin
                e = exp_q.pop_front();
                if (w !== e) begin failures++; $display("FAIL midreset_word got=%h exp=%h", w, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_missing pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        $display("test_mid_reset word=%h", WriteData);
    endtask

    initial begin
        clear_events();
        test_reset();
        test_word_packing();
        test_timeout();
        test_frame_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
